// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
// Stores header-tagged bytes and tracks how much of the current packet remains to drain.
`default_nettype none

module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic             full,
    output logic             empty,
    output logic             pkt_active
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [6:0]       pkt_count_q, pkt_count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_out_valid_q, data_out_valid_d;

    logic             wr_accept;
    logic             rd_accept;
    logic [WIDTH:0]   rd_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign wr_accept = write_enb && !full && !soft_reset;
    assign rd_accept = read_enb && !empty && !soft_reset;
    assign rd_word   = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // No reset on the array so it can map onto RAM; stale words are unreachable after a flush.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        pkt_count_d      = pkt_count_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        if (soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = '0;
            data_out_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_d         = rd_ptr_q + PTR_ONE;
                data_out_d       = rd_word[WIDTH-1:0];
                data_out_valid_d = 1'b1;
                // Header carries payload length in [7:2]; +1 accounts for the parity byte.
                if (rd_word[WIDTH]) begin
                    pkt_count_d = {1'b0, rd_word[7:2]} + 7'd1;
                end else if (pkt_count_q != 7'd0) begin
                    pkt_count_d = pkt_count_q - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            pkt_count_q      <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            pkt_count_q      <= pkt_count_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign pkt_active     = (pkt_count_q != 7'd0);

endmodule

`default_nettype wire
